wb_write_arbiter: RTL and testbench



---
 rtl/wb_write_arbiter_if.sv | 30 +++
 rtl/wb_write_arbiter.sv | 90 +++++++++
 tb/tb_wb_write_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_if.sv
// Writeback bus between the WB stage, the MAC unit, the regfile write port
// and the hazard unit. The arbiter sits on the slave side.
interface wb_write_arbiter_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_valid;
  logic [4:0]    pipe_rd;
  logic [31:0]   pipe_data;
  logic          mac_valid;
  logic [4:0]    mac_rd;
  logic [31:0]   mac_data;
  logic          mac_ready;
  logic          write_enable;
  logic [4:0]    w_addr;
  logic [31:0]   w_data;
  logic [31:0]   pending_mask;
  logic [CW-1:0] queue_count;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, mac_valid, mac_rd, mac_data,
    output mac_ready, write_enable, w_addr, w_data, pending_mask, queue_count
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data, mac_valid, mac_rd, mac_data,
    input  mac_ready, write_enable, w_addr, w_data, pending_mask, queue_count
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Regfile write-port arbiter: pipe results win every slot they use; MAC
// results wait in a small FIFO and drain into idle slots. A younger pipe
// write to the same rd kills queued MAC entries so they never overwrite it.
module wb_write_arbiter #(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  wb_write_arbiter_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]             wr_ptr, rd_ptr, count;
  logic [DEPTH-1:0]          live;
  logic [DEPTH-1:0][4:0]     rd_q;
  logic [DEPTH-1:0][31:0]    data_q;
  logic [IW-1:0]             wr_idx, rd_idx;
  logic                      full, empty, pipe_wr, push, pop;

  assign wr_idx  = wr_ptr[IW-1:0];
  assign rd_idx  = rd_ptr[IW-1:0];
  assign count   = wr_ptr - rd_ptr;
  assign full    = (wr_ptr == {~rd_ptr[PW-1], rd_ptr[IW-1:0]});
  assign empty   = (wr_ptr == rd_ptr);

  // rd == 0 writes are architecturally void on both sources
  assign pipe_wr = bus.pipe_valid && (bus.pipe_rd != 5'd0);
  assign push    = bus.mac_valid && bus.mac_ready && (bus.mac_rd != 5'd0);
  assign pop     = !pipe_wr && !empty;

  assign bus.mac_ready   = !reset && !full;
  assign bus.queue_count = count;

  // Pointers and live bits: kill on matching pipe write, retire on pop,
  // set on push last so a same-cycle enqueue is never killed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      live   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (pipe_wr && rd_q[i] == bus.pipe_rd) live[i] <= 1'b0;
      if (pop) begin
        live[rd_idx] <= 1'b0;
        rd_ptr       <= rd_ptr + PW'(1);
      end
      if (push) begin
        live[wr_idx] <= 1'b1;
        wr_ptr       <= wr_ptr + PW'(1);
      end
    end
  end

  // Payload storage; validity is carried by the pointers and live bits
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_idx]   <= bus.mac_rd;
      data_q[wr_idx] <= bus.mac_data;
    end
  end

  // Registered write port; addr/data hold on idle cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.write_enable <= 1'b0;
      bus.w_addr       <= '0;
      bus.w_data       <= '0;
    end else if (pipe_wr) begin
      bus.write_enable <= 1'b1;
      bus.w_addr       <= bus.pipe_rd;
      bus.w_data       <= bus.pipe_data;
    end else if (pop && live[rd_idx]) begin
      bus.write_enable <= 1'b1;
      bus.w_addr       <= rd_q[rd_idx];
      bus.w_data       <= data_q[rd_idx];
    end else begin
      bus.write_enable <= 1'b0;
    end
  end

  // Registers still owed a MAC result, for the hazard unit
  always_comb begin
    bus.pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live[i]) bus.pending_mask[rd_q[i]] = 1'b1;
    bus.pending_mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: pipe writes are expected exactly one
// cycle after they are driven; MAC writes are expected in push order, minus
// entries killed by younger pipe writes to the same register.
module tb_wb_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t pipe_q[$];
  exp_t mac_q[$];
  exp_t mon_e;

  wb_write_arbiter_if #(.DEPTH(4)) bus ();

  wb_write_arbiter #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Drive one cycle of stimulus, update the model, advance past the edge
  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    exp_t keep[$];
    bus.pipe_valid = pv;
    bus.pipe_rd    = prd;
    bus.pipe_data  = pd;
    bus.mac_valid  = mv;
    bus.mac_rd     = mrd;
    bus.mac_data   = md;
    if (pv && prd != 5'd0) begin
      keep = {};
      foreach (mac_q[k]) if (mac_q[k].rd != prd) keep.push_back(mac_q[k]);
      mac_q = keep;
      pipe_q.push_back('{cyc + 1, prd, pd});
    end
    if (mv && mrd != 5'd0) mac_q.push_back('{0, mrd, md});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Write-port monitor: every write must match the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (pipe_q.size() > 0 && pipe_q[0].cyc == cyc) begin
        mon_e = pipe_q.pop_front();
        chk("pipe_we", 32'(bus.write_enable), 32'd1);
        chk("pipe_addr", 32'(bus.w_addr), 32'(mon_e.rd));
        chk("pipe_data", bus.w_data, mon_e.data);
      end else if (bus.write_enable) begin
        if (mac_q.size() > 0) begin
          mon_e = mac_q.pop_front();
          chk("mac_addr", 32'(bus.w_addr), 32'(mon_e.rd));
          chk("mac_data", bus.w_data, mon_e.data);
        end else begin
          chk("spurious_we", 32'(bus.write_enable), 32'd0);
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.pipe_valid = 1'b0;
    bus.pipe_rd    = '0;
    bus.pipe_data  = '0;
    bus.mac_valid  = 1'b0;
    bus.mac_rd     = '0;
    bus.mac_data   = '0;

    // reset state
    #2;
    chk("rst_we", 32'(bus.write_enable), 32'd0);
    chk("rst_addr", 32'(bus.w_addr), 32'd0);
    chk("rst_data", bus.w_data, 32'd0);
    chk("rst_count", 32'(bus.queue_count), 32'd0);
    chk("rst_mask", bus.pending_mask, 32'd0);
    chk("rst_ready", 32'(bus.mac_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rel_ready", 32'(bus.mac_ready), 32'd1);
    chk("rel_count", 32'(bus.queue_count), 32'd0);
    @(posedge clk);
    #1;

    // single pipe write, one cycle wide, addr/data hold afterwards
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    chk("p_we_on", 32'(bus.write_enable), 32'd1);
    idle();
    chk("p_we_off", 32'(bus.write_enable), 32'd0);
    chk("p_addr_hold", 32'(bus.w_addr), 32'd5);
    chk("p_data_hold", bus.w_data, 32'hDEADBEEF);

    // two MAC pushes held back by pipe traffic, then drain in order
    step(1'b1, 5'd1, 32'd11, 1'b1, 5'd7, 32'h0000_0700);
    step(1'b1, 5'd1, 32'd12, 1'b1, 5'd9, 32'h0000_0900);
    chk("m_mask2", bus.pending_mask, 32'h0000_0280);
    chk("m_count2", 32'(bus.queue_count), 32'd2);
    idle();
    chk("m_mask1", bus.pending_mask, 32'h0000_0200);
    idle();
    chk("m_mask0", bus.pending_mask, 32'h0000_0000);
    chk("m_count0", 32'(bus.queue_count), 32'd0);

    // fill under continuous pipe writes (pointers wrap), then drain
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd3, 32'(100 + i), 1'b1, 5'(20 + i), 32'(32'h2000 + i));
    chk("f_count", 32'(bus.queue_count), 32'd4);
    chk("f_ready", 32'(bus.mac_ready), 32'd0);
    chk("f_mask", bus.pending_mask, 32'h00F0_0000);
    idle();
    chk("f_count3", 32'(bus.queue_count), 32'd3);
    chk("f_ready3", 32'(bus.mac_ready), 32'd1);
    for (int i = 0; i < 3; i++) idle();
    chk("f_count0", 32'(bus.queue_count), 32'd0);

    // WAW kill: queued r12 killed by younger pipe write
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h0000_1234);
    chk("k_mask", bus.pending_mask, 32'h0000_1000);
    step(1'b1, 5'd12, 32'd1, 1'b0, 5'd0, 32'h0);
    chk("k_mask_clr", bus.pending_mask, 32'h0);
    chk("k_count1", 32'(bus.queue_count), 32'd1);
    idle();
    chk("k_count0", 32'(bus.queue_count), 32'd0);
    chk("k_no_we", 32'(bus.write_enable), 32'd0);
    chk("k_last_data", bus.w_data, 32'd1);

    // same-cycle pipe and MAC to r14: the new entry survives
    step(1'b1, 5'd14, 32'h0000_00AA, 1'b1, 5'd14, 32'h0000_00BB);
    chk("s_mask", bus.pending_mask, 32'h0000_4000);
    idle();
    idle();
    chk("s_mask_clr", bus.pending_mask, 32'h0);

    // mac_rd == 0 is accepted and discarded
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_000F);
    chk("z_count", 32'(bus.queue_count), 32'd0);
    chk("z_ready", 32'(bus.mac_ready), 32'd1);
    chk("z_mask", bus.pending_mask, 32'h0);
    idle();

    // reset mid-operation with three entries queued and a write in flight
    step(1'b1, 5'd1, 32'd21, 1'b1, 5'd2, 32'h0000_0002);
    step(1'b1, 5'd1, 32'd22, 1'b1, 5'd3, 32'h0000_0003);
    step(1'b1, 5'd1, 32'd23, 1'b1, 5'd4, 32'h0000_0004);
    chk("r_count3", 32'(bus.queue_count), 32'd3);
    chk("r_mask3", bus.pending_mask, 32'h0000_001C);
    reset          = 1'b1;
    bus.pipe_valid = 1'b0;
    bus.mac_valid  = 1'b0;
    pipe_q         = {};
    mac_q          = {};
    #1;
    chk("r_count", 32'(bus.queue_count), 32'd0);
    chk("r_mask", bus.pending_mask, 32'h0);
    chk("r_we", 32'(bus.write_enable), 32'd0);
    chk("r_ready", 32'(bus.mac_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("r_ready_rel", 32'(bus.mac_ready), 32'd1);
    @(posedge clk);
    #1;
    idle();
    idle();
    chk("sb_pipe_empty", 32'(pipe_q.size()), 32'd0);
    chk("sb_mac_empty", 32'(mac_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
